// File: rtl/cla_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// FSM state encodings, nibble width and the debug view of the controller.
package cla_nibble_seq_pkg;

  // Raw state encodings, kept as plain constants so checkers can match on them.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Width of the shared lookahead adder slice.
  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  // Controller snapshot: current state, carry between nibbles, and whether the
  // nibble being processed this cycle is the most significant one.
  typedef struct packed {
    state_e state;
    logic   carry;
    logic   last_nib;
  } cla_seq_dbg_t;

endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead adder: all four carries are formed directly from the
// generate/propagate terms and the carry in, with no ripple between bits.
module cla_4 (
  output logic [3:0] S,
  output logic       C,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carry equations.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = C0;
    c[1] = g[0] | (p[0] & C0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & C0);
    S    = p ^ c[3:0];
    C    = c[4];
  end

endmodule

// File: rtl/cla_nibble_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit
// carry-lookahead adder. Operands are processed one nibble per cycle, LSB
// nibble first, with the carry held in a register between nibbles. WIDTH must
// be a multiple of 4 and at least 8.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; operands are sampled solely at the
// accept edge. out_valid is high only in DONE, and sum/cout/ovf stay stable
// until the edge where out_ready is seen high; after that out_valid drops and
// the result registers keep their last value.
module cla_nibble_seq
  import cla_nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output cla_seq_dbg_t     dbg
);

  localparam int NIB  = WIDTH / NIBW;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_e           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [NIBW-1:0]  nib_a;
  logic [NIBW-1:0]  nib_b;
  logic [NIBW-1:0]  nib_s;
  logic             nib_c;
  logic             last_nib;

  // Select the operand nibbles for the current step; the carry only ever
  // comes from carry_reg, so there is no combinational path from a/b to sum.
  always_comb begin
    nib_a    = op_a[NIBW*idx +: NIBW];
    nib_b    = op_b[NIBW*idx +: NIBW];
    last_nib = (idx == LAST_IDX);
  end

  cla_4 u_cla (
    .S  (nib_s),
    .C  (nib_c),
    .A  (nib_a),
    .B  (nib_b),
    .C0 (carry_reg)
  );

  // Controller, index counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the inversion and the +1 happen here.
            op_a      <= a;
            op_b      <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx       <= '0;
            sum_reg   <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_reg[NIBW*idx +: NIBW] <= nib_s;
          carry_reg                 <= nib_c;
          if (last_nib) begin
            cout_reg <= nib_c;
            ovf_reg  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (nib_s[NIBW-1] != op_a[WIDTH-1]);
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status flags decode directly from the state register.
  always_comb begin
    in_ready     = (state == ST_IDLE);
    out_valid    = (state == ST_DONE);
    busy         = (state != ST_IDLE);
    sum          = sum_reg;
    cout         = cout_reg;
    ovf          = ovf_reg;
    dbg.state    = state;
    dbg.carry    = carry_reg;
    dbg.last_nib = last_nib;
  end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq: table of directed vectors, random vectors checked
// against a plain integer model, and hand-written backpressure/reset sequences.
module tb_cla_nibble_seq;
  import cla_nibble_seq_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  cla_seq_dbg_t dbg;

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .dbg       (dbg)
  );

  // ---------------- scoreboard ----------------
  // Expected entries are {cout, ovf, sum}.
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: full-width integer add of a, the effective b and carry in.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         v;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb,
                      input logic scin, input logic ssub);
    bit ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("send in_ready timeout", 0, 1);
    a = sa; b = sb; cin = scin; sub = ssub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency and values, completes the transfer.
  task automatic collect(input string tag, input bit zero_ripple);
    int cyc = 0;
    logic [W+1:0] e;
    for (int c = 1; c <= NIB + 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin cyc = c; break; end
      if (zero_ripple) check({tag, " ripple sum"}, 32'(sum), 32'h0);
    end
    if (cyc == 0) begin
      check({tag, " out_valid timeout"}, 0, 1);
      return;
    end
    check({tag, " latency"}, cyc, NIB);
    if (exp_q.size() == 0) begin
      check({tag, " queue empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " sum"},  32'(sum),  32'(e[W-1:0]));
      check({tag, " cout"}, 32'(cout), 32'(e[W+1]));
      check({tag, " ovf"},  32'(ovf),  32'(e[W]));
    end
    @(posedge clk); #1;
    check({tag, " out_valid drop"}, 32'(out_valid), 0);
    check({tag, " in_ready back"},  32'(in_ready),  1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input logic rcin, input logic rsub, input logic [W+1:0] expv,
                        input bit zero_ripple);
    send(ra, rb, rcin, rsub);
    exp_q.push_back(expv);
    collect(tag, zero_ripple);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string        name;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] ra, rb;
    logic rc, rs;
    bit saw_valid;

    vecs[0] = '{"add_5555",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{"add_cin",     16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{"sub_noborrow",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{"sub_cin_ign", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{"add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst in_ready",  32'(in_ready),  1);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst sum",       32'(sum),       0);
    check("rst cout",      32'(cout),      0);
    check("rst ovf",       32'(ovf),       0);
    check("rst busy",      32'(busy),      0);
    check("rst state",     32'(dbg.state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Full ripple: every nibble produces 0 with carry 1.
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, 1'b1);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
             {vecs[i].ecout, vecs[i].eovf, vecs[i].esum}, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_op("random", ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0);
    end

    // Backpressure in DONE with noisy inputs.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 16'h3333});
    saw_valid = 0;
    for (int c = 0; c < NIB + 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin saw_valid = 1; break; end
    end
    check("bp reach done", 32'(saw_valid), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      @(posedge clk); #1;
      check("bp sum hold",   32'(sum),       32'h3333);
      check("bp cout hold",  32'(cout),      0);
      check("bp ovf hold",   32'(ovf),       0);
      check("bp in_ready",   32'(in_ready),  0);
      check("bp out_valid",  32'(out_valid), 1);
    end
    if (exp_q.size() != 0) begin
      logic [W+1:0] e;
      e = exp_q.pop_front();
      check("bp sum", 32'(sum), 32'(e[W-1:0]));
    end
    // Transfer edge with in_valid also high: must not be accepted.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp xfer out_valid", 32'(out_valid), 0);
    check("bp xfer in_ready",  32'(in_ready),  1);
    @(posedge clk); #1;
    check("bp no accept busy", 32'(busy), 0);
    check("bp sum kept",       32'(sum),  32'h3333);

    // Reset on the second RUN cycle discards the operation.
    send(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rr in run", 32'(dbg.state), 32'(ST_RUN));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rr in_ready",  32'(in_ready),  1);
    check("rr sum",       32'(sum),       0);
    check("rr out_valid", 32'(out_valid), 0);
    check("rr busy",      32'(busy),      0);
    saw_valid = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1;
    end
    check("rr no out_valid", 32'(saw_valid), 0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002}, 1'b0);

    check("queue drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
